// File: rtl/cas_sort_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cas_sort_ctrl_pkg
// Shared definitions for the batch sorter:
//   - BITS_DEFAULT       default word width
//   - ST_LOAD/SORT/DRAIN controller state encodings
//   - phase_t            EVEN/ODD window phase within a sort round
//   - even_windows/odd_windows/max_rounds_for  sizing helpers for a batch size
// No ports (package).
// -----------------------------------------------------------------------------
package cas_sort_ctrl_pkg;

   localparam int BITS_DEFAULT = 6;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_SORT  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef enum logic {
      PH_EVEN = 1'b0,
      PH_ODD  = 1'b1
   } phase_t;

   // Windows with bases 0,4,...,n-4
   function automatic int even_windows(input int n);
      return n / 4;
   endfunction

   // Windows with bases 2,6,...,n-6
   function automatic int odd_windows(input int n);
      return n / 4 - 1;
   endfunction

   // Safety bound on the number of EVEN+ODD rounds for a batch of n words
   function automatic int max_rounds_for(input int n);
      return n / 2 + 1;
   endfunction

endpackage

// File: rtl/cas_sort_ctrl_if.sv
// -----------------------------------------------------------------------------
// cas_sort_ctrl_if
// Input and output valid/ready streams of the batch sorter.
//   in_valid/in_ready/in_data            producer -> sorter
//   out_valid/out_ready/out_data/out_last sorter -> consumer
// Modports: master = producer/consumer side, slave = sorter side.
// -----------------------------------------------------------------------------
interface cas_sort_ctrl_if
   import cas_sort_ctrl_pkg::*;
#(
   parameter int BITS = BITS_DEFAULT
);
   logic            in_valid;
   logic            in_ready;
   logic [BITS-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [BITS-1:0] out_data;
   logic            out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/cas_sort_ctrl_cas4.sv
// -----------------------------------------------------------------------------
// cas_sort_ctrl_cas4
// Combinational 4-input compare-and-swap sorter, descending order.
//   a,b,c,d              input words
//   a_new..d_new         same words with a_new >= b_new >= c_new >= d_new
// Five-comparator network: sort the two pairs, pick global max/min from the
// pair extremes, then order the two middle survivors.
// -----------------------------------------------------------------------------
module cas_sort_ctrl_cas4
   import cas_sort_ctrl_pkg::*;
#(
   parameter int BITS = BITS_DEFAULT
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [BITS-1:0] c,
   input  logic [BITS-1:0] d,
   output logic [BITS-1:0] a_new,
   output logic [BITS-1:0] b_new,
   output logic [BITS-1:0] c_new,
   output logic [BITS-1:0] d_new
);
   logic [BITS-1:0] hi_ab, lo_ab, hi_cd, lo_cd, mid_x, mid_y;

   always_comb begin
      hi_ab = (a >= b) ? a : b;
      lo_ab = (a >= b) ? b : a;
      hi_cd = (c >= d) ? c : d;
      lo_cd = (c >= d) ? d : c;

      a_new = (hi_ab >= hi_cd) ? hi_ab : hi_cd;
      mid_x = (hi_ab >= hi_cd) ? hi_cd : hi_ab;
      d_new = (lo_ab >= lo_cd) ? lo_cd : lo_ab;
      mid_y = (lo_ab >= lo_cd) ? lo_ab : lo_cd;

      b_new = (mid_x >= mid_y) ? mid_x : mid_y;
      c_new = (mid_x >= mid_y) ? mid_y : mid_x;
   end
endmodule

// File: rtl/cas_sort_ctrl.sv
// -----------------------------------------------------------------------------
// cas_sort_ctrl
// Half-duplex batch sorter: loads NUM_ELEMS words, sorts them descending with a
// single time-shared cas4 over overlapping 4-word windows, then drains them.
//   clk, rst     clock and synchronous active-high reset
//   en           stalls the SORT state when low (LOAD/DRAIN unaffected)
//   bus          slave side of cas_sort_ctrl_if (input and output streams)
//   busy         high in SORT or DRAIN
//   rounds_used  rounds taken by the last sort
//   timeout      set if the round bound was hit; cleared when the next sort starts
// -----------------------------------------------------------------------------
module cas_sort_ctrl
   import cas_sort_ctrl_pkg::*;
#(
   parameter int BITS       = BITS_DEFAULT,
   parameter int NUM_ELEMS  = 8,
   parameter int MAX_ROUNDS = max_rounds_for(NUM_ELEMS),
   parameter int RW         = $clog2(MAX_ROUNDS + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   cas_sort_ctrl_if.slave      bus,
   output logic                busy,
   output logic [RW-1:0]       rounds_used,
   output logic                timeout
);
   localparam int IW     = $clog2(NUM_ELEMS);
   localparam int EVEN_W = even_windows(NUM_ELEMS);
   localparam int ODD_W  = odd_windows(NUM_ELEMS);
   localparam int WW     = $clog2(EVEN_W);

   localparam logic [WW-1:0] EVEN_LAST   = WW'(EVEN_W - 1);
   localparam logic [WW-1:0] ODD_LAST    = WW'(ODD_W - 1);
   localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_ELEMS - 1);
   localparam logic [RW-1:0] ROUND_LIMIT = RW'(MAX_ROUNDS);

   logic [1:0]      state_reg;
   logic [IW-1:0]   wr_idx_reg;
   logic [IW-1:0]   rd_idx_reg;
   logic [WW-1:0]   win_idx_reg;
   phase_t          phase_reg;
   logic            changed_reg;
   logic [RW-1:0]   round_cnt_reg;
   logic [RW-1:0]   rounds_used_reg;
   logic            timeout_reg;

   logic [BITS-1:0] buf_mem [NUM_ELEMS];

   logic [IW-1:0]   win_base;
   logic [BITS-1:0] win_old [4];
   logic [BITS-1:0] win_new [4];
   logic [3:0]      win_diff;
   logic            window_dirty;
   logic            last_window;
   logic [RW-1:0]   round_next;

   // ODD windows are the EVEN windows shifted by two, so they straddle the
   // boundary between neighbouring EVEN windows.
   assign win_base = IW'({win_idx_reg, 2'b00}) + ((phase_reg == PH_ODD) ? IW'(2) : IW'(0));

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_win
         assign win_old[gi]  = buf_mem[win_base + IW'(gi)];
         assign win_diff[gi] = (win_new[gi] != win_old[gi]);
      end
   endgenerate

   cas_sort_ctrl_cas4 #(.BITS(BITS)) u_cas4 (
      .a     (win_old[0]),
      .b     (win_old[1]),
      .c     (win_old[2]),
      .d     (win_old[3]),
      .a_new (win_new[0]),
      .b_new (win_new[1]),
      .c_new (win_new[2]),
      .d_new (win_new[3])
   );

   // Includes the window being written this cycle, so the round-end decision
   // sees every swap of the round.
   assign window_dirty = changed_reg | (|win_diff);
   assign last_window  = (phase_reg == PH_EVEN) ? (win_idx_reg == EVEN_LAST)
                                                : (win_idx_reg == ODD_LAST);
   assign round_next   = round_cnt_reg + RW'(1);

   // Buffer contents need no reset; LOAD overwrites every entry.
   always_ff @(posedge clk) begin
      if (state_reg == ST_LOAD && bus.in_valid) begin
         buf_mem[wr_idx_reg] <= bus.in_data;
      end else if (state_reg == ST_SORT && en) begin
         for (int i = 0; i < 4; i++) begin
            buf_mem[win_base + IW'(i)] <= win_new[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_LOAD;
         wr_idx_reg      <= '0;
         rd_idx_reg      <= '0;
         win_idx_reg     <= '0;
         phase_reg       <= PH_EVEN;
         changed_reg     <= 1'b0;
         round_cnt_reg   <= '0;
         rounds_used_reg <= '0;
         timeout_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_LOAD: begin
               if (bus.in_valid) begin
                  if (wr_idx_reg == LAST_IDX) begin
                     wr_idx_reg      <= '0;
                     state_reg       <= ST_SORT;
                     win_idx_reg     <= '0;
                     phase_reg       <= PH_EVEN;
                     changed_reg     <= 1'b0;
                     round_cnt_reg   <= '0;
                     rounds_used_reg <= '0;
                     timeout_reg     <= 1'b0;
                  end else begin
                     wr_idx_reg <= wr_idx_reg + IW'(1);
                  end
               end
            end
            ST_SORT: begin
               if (en) begin
                  if (!last_window) begin
                     win_idx_reg <= win_idx_reg + WW'(1);
                     changed_reg <= window_dirty;
                  end else if (phase_reg == PH_EVEN) begin
                     phase_reg   <= PH_ODD;
                     win_idx_reg <= '0;
                     changed_reg <= window_dirty;
                  end else begin
                     round_cnt_reg <= round_next;
                     win_idx_reg   <= '0;
                     phase_reg     <= PH_EVEN;
                     changed_reg   <= 1'b0;
                     if (!window_dirty) begin
                        state_reg       <= ST_DRAIN;
                        rounds_used_reg <= round_next;
                     end else if (round_next == ROUND_LIMIT) begin
                        state_reg       <= ST_DRAIN;
                        rounds_used_reg <= round_next;
                        timeout_reg     <= 1'b1;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (bus.out_ready) begin
                  if (rd_idx_reg == LAST_IDX) begin
                     rd_idx_reg <= '0;
                     state_reg  <= ST_LOAD;
                  end else begin
                     rd_idx_reg <= rd_idx_reg + IW'(1);
                  end
               end
            end
            default: state_reg <= ST_LOAD;
         endcase
      end
   end

   assign bus.in_ready  = (state_reg == ST_LOAD);
   assign bus.out_valid = (state_reg == ST_DRAIN);
   assign bus.out_data  = buf_mem[rd_idx_reg];
   assign bus.out_last  = (state_reg == ST_DRAIN) && (rd_idx_reg == LAST_IDX);
   assign busy          = (state_reg == ST_SORT) || (state_reg == ST_DRAIN);
   assign rounds_used   = rounds_used_reg;
   assign timeout       = timeout_reg;
endmodule
